// File: rtl/rv523_shift_pkg.sv
// Shared definitions for the RV523 iterative shifter: op encodings,
// FSM state type and the default datapath width.
package rv523_shift_pkg;

  localparam int XLEN_DEFAULT = 32;

  // bit0 selects right shift, bit1 selects arithmetic fill (right only)
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/rv523_shift_step.sv
// One combinational shift step for the RV523 shifter: shifts the working
// value by 1 or by 4 positions, left or right, with zero or sign fill.
// An arithmetic op without the right bit (2'b10) shifts left.
module rv523_shift_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [1:0]      i_op,
  input  logic            i_step4,
  output logic [XLEN-1:0] o_data
);

  logic w_right;
  logic w_fill;

  assign w_right = i_op[0];
  // Sign bit is taken from the value before this step
  assign w_fill  = i_op[1] & i_op[0] & i_data[XLEN-1];

  // Select direction and distance for this step
  always_comb begin
    o_data = i_data;
    if (w_right) begin
      if (i_step4) o_data = {{4{w_fill}}, i_data[XLEN-1:4]};
      else         o_data = {w_fill, i_data[XLEN-1:1]};
    end else begin
      if (i_step4) o_data = {i_data[XLEN-5:0], 4'b0000};
      else         o_data = {i_data[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv523_shift_unit.sv
// RV523 execute-stage shifter (SLL/SRL/SRA and immediate forms).
// Iterative: one shift step per clock instead of a full barrel shifter.
// Optional macro RV523_SHIFT_STEP4_EN: take 4-bit steps while at least
// four positions remain, then finish with 1-bit steps. Results are the
// same either way; only the latency changes.
module rv523_shift_unit
  import rv523_shift_pkg::*;
#(
  parameter  int XLEN = XLEN_DEFAULT,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            KILL,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [1:0]      IN_OP,
  input  logic [XLEN-1:0] IN_DATA,
  input  logic [SHW-1:0]  IN_SHAMT,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_DATA
);

  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_FOUR = SHW'(4);

  shift_state_e    r_state;
  logic [XLEN-1:0] r_data;
  logic [SHW-1:0]  r_cnt;
  logic [1:0]      r_op;

  logic            w_step4;
  logic [XLEN-1:0] w_step_data;
  logic [SHW-1:0]  w_cnt_nxt;

`ifdef RV523_SHIFT_STEP4_EN
  assign w_step4 = (r_cnt >= CNT_FOUR);
`else
  assign w_step4 = 1'b0;
`endif

  assign w_cnt_nxt = r_cnt - (w_step4 ? CNT_FOUR : CNT_ONE);

  rv523_shift_step #(
    .XLEN (XLEN)
  ) u_step (
    .i_data  (r_data),
    .i_op    (r_op),
    .i_step4 (w_step4),
    .o_data  (w_step_data)
  );

  assign IN_READY  = (r_state == IDLE) && !KILL;
  assign OUT_VALID = (r_state == DONE);
  assign OUT_DATA  = r_data;

  // Handshake FSM: accept, iterate shift steps, hold result until taken
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
    end else if (KILL) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_data  <= IN_DATA;
            r_cnt   <= IN_SHAMT;
            r_op    <= IN_OP;
            r_state <= (IN_SHAMT == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          r_data <= w_step_data;
          r_cnt  <= w_cnt_nxt;
          if (w_cnt_nxt == '0) r_state <= DONE;
        end
        DONE: begin
          if (OUT_READY) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
